// File: rtl/ori_hist_acc_if.sv
// Sample/result handshake bundle between the direction-bin ROM front end,
// the orientation-histogram accumulator and its result consumer.
interface ori_hist_acc_if #(
  parameter int MAG_W = 8,
  parameter int ACC_W = 16
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_dir;
  logic [MAG_W-1:0] in_mag;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_bin;
  logic [ACC_W-1:0] out_val;
  logic             busy;

  modport master (
    output start, in_valid, in_dir, in_mag, in_last, out_ready,
    input  in_ready, out_valid, out_bin, out_val, busy
  );

  modport slave (
    input  start, in_valid, in_dir, in_mag, in_last, out_ready,
    output in_ready, out_valid, out_bin, out_val, busy
  );
endinterface

// File: rtl/ori_hist_acc.sv
// Orientation-histogram accumulator: saturating 32-bin magnitude histogram per
// keypoint window, followed by a 32-cycle peak scan (ties go to the lowest bin).
module ori_hist_acc #(
  parameter int MAG_W = 8,
  parameter int ACC_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  ori_hist_acc_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Widen by one bit so the carry out of the bin is visible, then clamp.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [MAG_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W + 1 - MAG_W){1'b0}}, b};
    if (s[ACC_W]) begin
      sat_add = {ACC_W{1'b1}};
    end else begin
      sat_add = s[ACC_W-1:0];
    end
  endfunction

  logic [1:0]       state_r;
  logic [ACC_W-1:0] bins_r [32];
  logic [4:0]       scan_idx_r;
  logic [ACC_W-1:0] best_val_r;
  logic [4:0]       best_bin_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [4:0]       out_bin_r;
  logic [ACC_W-1:0] out_val_r;
  logic             busy_r;

  logic             accept_s;
  logic [ACC_W-1:0] acc_sum_s;
  logic [ACC_W-1:0] cand_val_s;
  logic [ACC_W-1:0] nxt_val_s;
  logic [4:0]       nxt_bin_s;

  assign accept_s = bus.in_valid & in_ready_r;

  // Saturating read-modify-write value for the addressed bin.
  always_comb begin
    acc_sum_s = sat_add(bins_r[bus.in_dir], bus.in_mag);
  end

  // Running peak after considering the bin at the current scan index.
  always_comb begin
    cand_val_s = bins_r[scan_idx_r];
    nxt_val_s  = best_val_r;
    nxt_bin_s  = best_bin_r;
    if ((scan_idx_r == 5'd0) || (cand_val_s > best_val_r)) begin
      nxt_val_s = cand_val_s;
      nxt_bin_s = scan_idx_r;
    end else begin
      nxt_val_s = best_val_r;
      nxt_bin_s = best_bin_r;
    end
  end

  // Window control FSM, histogram storage and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      for (int i = 0; i < 32; i++) begin
        bins_r[i] <= {ACC_W{1'b0}};
      end
      scan_idx_r  <= 5'd0;
      best_val_r  <= {ACC_W{1'b0}};
      best_bin_r  <= 5'd0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_bin_r   <= 5'd0;
      out_val_r   <= {ACC_W{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < 32; i++) begin
              bins_r[i] <= {ACC_W{1'b0}};
            end
            state_r    <= ST_ACC;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        ST_ACC: begin
          if (accept_s) begin
            bins_r[bus.in_dir] <= acc_sum_s;
            if (bus.in_last) begin
              state_r    <= ST_SCAN;
              in_ready_r <= 1'b0;
              scan_idx_r <= 5'd0;
            end
          end
        end
        ST_SCAN: begin
          best_val_r <= nxt_val_s;
          best_bin_r <= nxt_bin_s;
          scan_idx_r <= scan_idx_r + 5'd1;
          // The final compare feeds the outputs directly so DONE starts valid.
          if (scan_idx_r == 5'd31) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            out_bin_r   <= nxt_bin_s;
            out_val_r   <= nxt_val_s;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_bin   = out_bin_r;
  assign bus.out_val   = out_val_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_ori_hist_acc.sv
// Directed bench for ori_hist_acc: table of short windows plus hand-written
// sequences for reset, saturation, backpressure and ignored inputs.
module tb_ori_hist_acc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ori_hist_acc_if #(.MAG_W(8), .ACC_W(16)) bus ();

  ori_hist_acc #(.MAG_W(8), .ACC_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0]      n;
    logic [3:0][4:0] dir;
    logic [3:0][7:0] mag;
    logic [4:0]      exp_bin;
    logic [15:0]     exp_val;
  } win_t;

  int total = 0;
  int bad = 0;
  win_t vec [6];

  function automatic win_t mk(input int n,
                              input int d0, input int m0, input int d1, input int m1,
                              input int d2, input int m2, input int d3, input int m3,
                              input int eb, input int ev);
    win_t w;
    w.n = 3'(n);
    w.dir[0] = 5'(d0); w.mag[0] = 8'(m0);
    w.dir[1] = 5'(d1); w.mag[1] = 8'(m1);
    w.dir[2] = 5'(d2); w.mag[2] = 8'(m2);
    w.dir[3] = 5'(d3); w.mag[3] = 8'(m3);
    w.exp_bin = 5'(eb);
    w.exp_val = 16'(ev);
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_win();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("in_ready_after_start", 32'(bus.in_ready), 32'd1);
  endtask

  // Drive one sample and hold it until the edge that accepts it.
  task automatic send(input logic [4:0] d, input logic [7:0] m, input logic last);
    int w;
    bus.in_valid = 1'b1;
    bus.in_dir   = d;
    bus.in_mag   = m;
    bus.in_last  = last;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) check("send_timeout", 32'd0, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Count edges after the last accept until out_valid; 32 means high in cycle T+33.
  task automatic wait_result(input string name);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd32);
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
    check("busy_after_hs", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_dir = 5'd0;
    bus.in_mag = 8'd0; bus.in_last = 1'b0; bus.out_ready = 1'b0;

    vec[0] = mk(4, 5, 10, 5, 10, 5, 10, 7, 20, 5, 30);
    vec[1] = mk(2, 20, 50, 3, 50, 0, 0, 0, 0, 3, 50);
    vec[2] = mk(2, 0, 1, 31, 2, 0, 0, 0, 0, 31, 2);
    vec[3] = mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 2, 1);
    vec[4] = mk(2, 9, 0, 4, 0, 0, 0, 0, 0, 0, 0);
    vec[5] = mk(4, 12, 255, 12, 255, 30, 200, 12, 1, 12, 511);

    // Reset state
    tick(); tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out_bin", 32'(bus.out_bin), 32'd0);
    check("rst_out_val", 32'(bus.out_val), 32'd0);
    rst_n = 1'b1;
    tick();

    // Table of windows, each restarted on the cycle right after the handshake
    for (int v = 0; v < 6; v++) begin
      start_win();
      for (int s = 0; s < int'(vec[v].n); s++) begin
        send(vec[v].dir[s], vec[v].mag[s], (s == int'(vec[v].n) - 1));
      end
      wait_result("tbl");
      check("tbl_out_bin", 32'(bus.out_bin), 32'(vec[v].exp_bin));
      check("tbl_out_val", 32'(bus.out_val), 32'(vec[v].exp_val));
      take_result();
      check("tbl_hold_bin", 32'(bus.out_bin), 32'(vec[v].exp_bin));
    end

    // Asynchronous reset mid-window, then a clean window
    start_win();
    send(5'd4, 8'd100, 1'b0);
    send(5'd4, 8'd100, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    start_win();
    send(5'd2, 8'd1, 1'b1);
    wait_result("midrst");
    check("midrst_out_bin", 32'(bus.out_bin), 32'd2);
    check("midrst_out_val", 32'(bus.out_val), 32'd1);
    take_result();

    // Saturation: 300 x 255 into bin 31 clamps at 65535
    start_win();
    for (int i = 0; i < 300; i++) send(5'd31, 8'd255, 1'b0);
    send(5'd0, 8'd1, 1'b1);
    wait_result("sat");
    check("sat_out_bin", 32'(bus.out_bin), 32'd31);
    check("sat_out_val", 32'(bus.out_val), 32'd65535);
    take_result();

    // Ignored start pulses and samples outside ACC, plus DONE backpressure
    start_win();
    send(5'd6, 8'd3, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("acc_start_ignored_ready", 32'(bus.in_ready), 32'd1);
    send(5'd8, 8'd4, 1'b1);
    bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_dir = 5'd1; bus.in_mag = 8'd200;
    tick();
    check("scan_in_ready", 32'(bus.in_ready), 32'd0);
    bus.start = 1'b0; bus.in_valid = 1'b0;
    for (int i = 0; i < 40 && !bus.out_valid; i++) tick();
    check("bp_out_bin", 32'(bus.out_bin), 32'd8);
    check("bp_out_val", 32'(bus.out_val), 32'd4);
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 2);
      tick();
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_bin", 32'(bus.out_bin), 32'd8);
      check("bp_hold_val", 32'(bus.out_val), 32'd4);
    end
    bus.start = 1'b0;
    take_result();
    bus.in_valid = 1'b1; bus.in_dir = 5'd1; bus.in_mag = 8'd200;
    tick(); tick();
    check("idle_in_ready", 32'(bus.in_ready), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    bus.in_valid = 1'b0;
    start_win();
    send(5'd10, 8'd5, 1'b1);
    wait_result("post");
    check("post_out_bin", 32'(bus.out_bin), 32'd10);
    check("post_out_val", 32'(bus.out_val), 32'd5);
    take_result();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ori_hist_acc.md
# ori_hist_acc

Orientation-histogram accumulator that sits directly downstream of the direction-bin lookup ROMs. For each sample it takes a 5-bit direction bin (0..31) from the ROM and a gradient magnitude, and adds the magnitude into one of 32 bins. After the last sample of a keypoint window it scans the histogram and reports the peak bin and its value as the keypoint's main orientation.

## Interface
- MAG_W, 8: gradient magnitude width.
- ACC_W, 16: bin accumulator width. Must be at least MAG_W.

- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that clears the histogram and opens a window. Honoured only in IDLE.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accept. Equals 1 only in ACC.
- in_dir  in  5  direction bin, driven from the ROM spo.
- in_mag  in  MAG_W  gradient magnitude, unsigned.
- in_last  in  1  marks the final sample of the window. Qualified by in_valid & in_ready.
- out_valid  out  1  result valid. Held until accepted.
- out_ready  in  1  result accept.
- out_bin  out  5  index of the peak bin.
- out_val  out  ACC_W  value of the peak bin.
- busy  out  1  high in every state other than IDLE.

## Operation
- FSM states: IDLE, ACC, SCAN, DONE. Reset state is IDLE.
- Reset values:
  - all 32 bins = 0
  - in_ready = 0, out_valid = 0, out_bin = 0, out_val = 0, busy = 0
  - scan index = 0
- IDLE:
  - start = 1: clear all 32 bins in that clock edge, then go to ACC.
  - Other inputs are ignored.
- ACC:
  - Each accepted sample updates `bin[in_dir] <= sat(bin[in_dir] + in_mag)`.
  - sat clamps the sum at 2^ACC_W − 1; the bin never wraps.
  - An accepted sample with in_last = 1 is accumulated, then the FSM goes to SCAN.
  - start is ignored in ACC.
- SCAN:
  - Takes 32 cycles with index i = 0..31.
  - At i = 0: best_val = bin[0], best_bin = 0.
  - At i > 0: replace the best only if bin[i] > best_val (strict compare), so ties resolve to the lowest index.
  - After i = 31, go to DONE.
- DONE:
  - out_valid = 1, with out_bin and out_val stable.
  - On out_valid & out_ready, return to IDLE with out_valid = 0.
  - out_bin and out_val keep their last values until the next DONE.
- Unaccepted inputs: in_valid while in_ready = 0 is dropped; nothing is accumulated.
- Empty or zero histogram: result is out_bin = 0, out_val = 0.
- Arithmetic: the sum is computed at ACC_W+1 bits and saturated back to ACC_W. in_mag is zero-extended.

## Timing
- Accumulate throughput: one sample per cycle, including back-to-back samples to the same bin. The read-modify-write completes in one cycle, so no hazard stall is needed.
- Start-up: start at cycle S gives in_ready = 1 from S+1.
- Result latency: if the last sample is accepted at cycle T, SCAN runs T+1..T+32 and out_valid rises at T+33.
- Last-sample visibility: the last sample's contribution is visible to the scan.
- Restart: minimum gap from out handshake (IDLE at H+1) to a new start is 0 cycles. start at H+1 is honoured.
- Reset mid-operation: asynchronous rst_n in any state forces IDLE and zeroes bins and outputs immediately. The next window sees no residue from the aborted one.

## Test plan
- Reset: assert rst_n = 0 mid-ACC with bins non-zero → in_ready = 0, busy = 0, out_valid = 0. A subsequent window containing dir 2 / mag 1 only reports out_bin = 2, out_val = 1.
- Basic peak: start; send dir 5 / mag 10 three times, then dir 7 / mag 20 with in_last → out_valid exactly 33 cycles after the last accept, out_bin = 5, out_val = 30.
- Tie: send dir 20 / mag 50, then dir 3 / mag 50 (last) → out_bin = 3, out_val = 50.
- Saturation (ACC_W = 16): send 300 back-to-back samples of dir 31 / mag 255, plus dir 0 / mag 1 → out_bin = 31, out_val = 65535.
- Handshake and backpressure:
  - Hold out_ready = 0 for 5 cycles in DONE → out_valid held high with stable outputs.
  - start pulses during ACC, SCAN and DONE are ignored.
  - in_valid in IDLE/SCAN does not change bins; check by reading the result of the following window.
- Wrap bins: send dir 0 / mag 1, dir 31 / mag 2 (last) → out_bin = 31, out_val = 2. Then pulse start on the cycle after the handshake → accepted; in_ready rises the next cycle.
